// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM for the multicycle MIPS datapath.
// Define MC_BNE_EN to add bne support through the BNEEX state.
module mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               alusrca,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic [2:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic [1:0]         lb,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, ADDIEX, ANDIEX, IMMWB, JEX, BNEEX
  } state_t;
  state_t state_q, state_d;
  logic pcwrite, branch, branch_n, r_ok;
  logic [2:0] r_alu;
  assign r_ok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  assign r_alu = funct == 6'b100010 ? 3'b110 :
                 funct == 6'b100100 ? 3'b000 :
                 funct == 6'b100101 ? 3'b001 :
                 funct == 6'b101010 ? 3'b111 : 3'b010;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = FETCH;
    pcwrite = 1'b0;
    branch = 1'b0;
    branch_n = 1'b0;
    irwrite = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    illegal = 1'b0;
    alusrca = 1'b0;
    iord = 1'b0;
    memtoreg = 1'b0;
    regdst = 1'b0;
    alusrcb = 3'b000;
    pcsrc = 2'b00;
    alucontrol = 3'b010;
    lb = 2'b00;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 3'b001;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 3'b011;
        case (op)
          6'b100011, 6'b101011, 6'b100000, 6'b100100: state_d = MEMADR;
          6'b000000: begin
            if (r_ok) state_d = RTYPEEX;
            illegal = !r_ok;
          end
          6'b000100: state_d = BEQEX;
          6'b001000: state_d = ADDIEX;
          6'b001100: state_d = ANDIEX;
          6'b000010: state_d = JEX;
`ifdef MC_BNE_EN
          6'b000101: state_d = BNEEX;
`endif
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        state_d = op == 6'b101011 ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        lb = op == 6'b100000 ? 2'b10 : op == 6'b100100 ? 2'b01 : 2'b00;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        alucontrol = r_alu;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        alucontrol = 3'b110;
        pcsrc = 2'b01;
        branch = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        state_d = IMMWB;
      end
      ANDIEX: begin
        alusrca = 1'b1;
        alusrcb = 3'b100;
        alucontrol = 3'b000;
        state_d = IMMWB;
      end
      IMMWB: regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        alucontrol = 3'b110;
        pcsrc = 2'b01;
        branch_n = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
    // While reset is held the state is already FETCH; only the strobes need masking.
    if (!reset) begin
      pcwrite = 1'b0;
      branch = 1'b0;
      branch_n = 1'b0;
      irwrite = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal = 1'b0;
    end
  end
  assign pcen = pcwrite | (branch & zero) | (branch_n & ~zero);
  assign state = state_q;
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit, directly upstream of the multicycle datapath.
- Consumes op/funct/zero from the datapath.
- Drives every datapath select/enable plus the memory write strobe, one Moore state per instruction phase.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, andi, j, lb, lbu.

Parameters:
- STATE_W, 4, width of the state register and of the debug state port.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op  in  6  instr[31:26] from datapath.
- funct  in  6  instr[5:0] from datapath.
- zero  in  1  ALU zero flag, same cycle.
- pcen  out  1  PC register enable.
- irwrite  out  1  instruction register enable.
- regwrite  out  1  register file write.
- memwrite  out  1  data memory write strobe.
- alusrca  out  1  0=pc, 1=A.
- iord  out  1  0=pc, 1=aluout address.
- memtoreg  out  1  0=aluout, 1=data.
- regdst  out  1  0=rt, 1=rd.
- alusrcb  out  3  000=B, 001=4, 010=signimm, 011=signimm<<2, 100=zeroimm.
- pcsrc  out  2  00=aluresult, 01=aluout, 10=jump target.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- lb  out  2  00 word, 01 byte zero-extend, 10 byte sign-extend.
- illegal  out  1  one-cycle pulse in DECODE on an unsupported op/funct.
- state  out  STATE_W  current state, for debug.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ANDIEX, IMMWB, JEX; BNEEX only with the optional feature.
- Reset asserted: state=FETCH asynchronously. All strobes (pcen, irwrite, regwrite, memwrite, illegal) are forced 0 combinationally. Selects take their FETCH values.
- Deasserting reset mid-instruction always restarts at FETCH.
- All outputs except pcen are Moore (decoded from state only). pcen = pcwrite | (branch & zero).
- Default values in every state: strobes 0, all selects 0, alucontrol 010.
- FETCH: iord 0, irwrite 1, alusrca 0, alusrcb 001, add, pcsrc 00, pcwrite 1. Next state DECODE.
- DECODE: alusrca 0, alusrcb 011, add (branch target into aluout). Next state by op:
  - 100011/101011/100000/100100 -> MEMADR.
  - 000000 -> RTYPEEX.
  - 000100 -> BEQEX.
  - 001000 -> ADDIEX.
  - 001100 -> ANDIEX.
  - 000010 -> JEX.
  - anything else -> FETCH with illegal=1.
- R-type with funct outside {100000, 100010, 100100, 100101, 101010} -> illegal=1 and next state FETCH.
- MEMADR: alusrca 1, alusrcb 010, add. Next state MEMWR for sw, else MEMRD.
- MEMRD: iord 1, lb = 00 (lw), 01 (lbu), 10 (lb). The datapath data register captures at the end of this cycle. Next state MEMWB.
- MEMWB: regdst 0, memtoreg 1, regwrite 1. Next state FETCH.
- MEMWR: iord 1, memwrite 1. Next state FETCH.
- RTYPEEX: alusrca 1, alusrcb 000, alucontrol from funct (add/sub/and/or/slt map to 010/110/000/001/111). Next state RTYPEWB.
- RTYPEWB: regdst 1, memtoreg 0, regwrite 1. Next state FETCH.
- BEQEX: alusrca 1, alusrcb 000, sub, pcsrc 01, branch 1. Next state FETCH.
- ADDIEX: alusrca 1, alusrcb 010, add. Next state IMMWB.
- ANDIEX: alusrca 1, alusrcb 100, and. Next state IMMWB.
- IMMWB: regdst 0, memtoreg 0, regwrite 1. Next state FETCH.
- JEX: pcsrc 10, pcwrite 1. Next state FETCH.
- Latency in cycles, FETCH inclusive: lw/lb/lbu 5, sw/R/addi/andi 4, beq/j 3, illegal 2.
- Decode must use the op/funct held in the datapath IR from DECODE onward; the controller stores no copy of the instruction.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined: op 000101 -> BNEEX. BNEEX equals BEQEX except pcen = ~zero. Latency 3.
- Undefined: op 000101 is illegal (pulse illegal, return to FETCH). BNEEX is not synthesized.

Test Plan:
- Release reset, op=100011 -> FETCH(pcen=1, irwrite=1), DECODE, MEMADR(alusrcb=010), MEMRD(iord=1, lb=00), MEMWB(regwrite=1, memtoreg=1), back to FETCH after 5 cycles.
- op=000000, funct=101010 -> RTYPEEX alucontrol=111, alusrcb=000; RTYPEWB regdst=1, regwrite=1.
- op=000100 in BEQEX with zero=1 -> pcen=1, pcsrc=01, alucontrol=110; repeat with zero=0 -> pcen=0.
- op=100000 -> MEMRD lb=10; op=100100 -> MEMRD lb=01; op=001100 -> ANDIEX alusrcb=100, alucontrol=000.
- op=111111 in DECODE -> illegal=1 for one cycle, next state FETCH; op=000101 gives the same result with MC_BNE_EN undefined, and BNEEX pcen=~zero with it defined.
- Drop reset to 0 during MEMRD -> state=FETCH immediately and all strobes 0 while held; release -> first cycle is FETCH with pcen=1.
